// File: rtl/seq_normalizer_if.sv
// Handshake bundle for seq_normalizer.
//   Input side : in_valid/in_ready plus the adder's biased exponent and raw sum.
//   Output side: out_valid/out_ready plus the normalised exponent and mantissa,
//                the status flags (sticky, zero, overflow, underflow) and busy.
// The master modport is the environment (adder upstream plus packer downstream).
// The slave modport is the normalizer itself.
interface seq_normalizer_if #(
    parameter int unsigned EXP_WIDTH      = 8,
    parameter int unsigned MANTISSA_WIDTH = 23
);
    logic                      in_valid;
    logic                      in_ready;
    logic [EXP_WIDTH-1:0]      expoent_in;
    logic [MANTISSA_WIDTH+1:0] result_in;

    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_WIDTH-1:0]      normal_e_out;
    logic [MANTISSA_WIDTH:0]   normal_m_out;
    logic                      sticky_out;
    logic                      zero_out;
    logic                      overflow_out;
    logic                      underflow_out;
    logic                      busy_out;

    modport master (
        output in_valid, expoent_in, result_in, out_ready,
        input  in_ready, out_valid, normal_e_out, normal_m_out,
        input  sticky_out, zero_out, overflow_out, underflow_out, busy_out
    );

    modport slave (
        input  in_valid, expoent_in, result_in, out_ready,
        output in_ready, out_valid, normal_e_out, normal_m_out,
        output sticky_out, zero_out, overflow_out, underflow_out, busy_out
    );
endinterface

// File: rtl/seq_normalizer.sv
// Multi-cycle post-add normalizer for the floating-point adder datapath.
// It takes the raw mantissa sum and the biased exponent. A carry out is absorbed
// with a one-bit right shift, and the bit shifted out is reported as sticky.
// Leading zeros are removed by left-shifting at most SHIFT_STEP bits per cycle.
// It also detects exact zero, overflow to infinity and underflow to denormal.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - seq_normalizer_if.slave: in_valid/in_ready, expoent_in, result_in,
//           out_valid/out_ready, normal_e_out, normal_m_out, sticky_out,
//           zero_out, overflow_out, underflow_out, busy_out
module seq_normalizer #(
    parameter int unsigned EXP_WIDTH      = 8,
    parameter int unsigned MANTISSA_WIDTH = 23,
    parameter int unsigned SHIFT_STEP     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_normalizer_if.slave   bus
);
    localparam int unsigned EW = EXP_WIDTH;
    localparam int unsigned MW = MANTISSA_WIDTH;
    // Exponent arithmetic is one bit wider so that +1 and -amt cannot wrap.
    localparam int unsigned XW = EXP_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   e_q, e_d;
    logic [MW:0]     m_q, m_d;
    logic            sticky_q, sticky_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [XW-1:0]   exp_in_w;
    logic [XW-1:0]   exp_p1;
    logic [XW-1:0]   all_ones;
    logic [XW-1:0]   lz;
    logic [XW-1:0]   e_m1;
    logic [XW-1:0]   amt;
    logic [XW-1:0]   e_shifted;
    logic [MW:0]     m_shift;

    // Capture-side exponent helpers.
    always_comb begin
        exp_in_w = {1'b0, bus.expoent_in};
        exp_p1   = exp_in_w + XW'(1);
        all_ones = {1'b0, {EW{1'b1}}};
    end

    // One shift step. The shift is bounded by the leading zeros in the top
    // window and by e-1, so the exponent stops at 1 (the denormal boundary).
    always_comb begin
        lz = XW'(SHIFT_STEP);
        // Scan from the bottom of the window up, so the topmost set bit wins.
        for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
            if (m_q[MW - i]) begin
                lz = XW'(i);
            end
        end
        e_m1      = {1'b0, e_q} - XW'(1);
        amt       = (lz < e_m1) ? lz : e_m1;
        m_shift   = m_q << amt;
        e_shifted = {1'b0, e_q} - amt;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        m_d      = m_q;
        sticky_d = sticky_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sticky_d = 1'b0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = StDone;
                    if (bus.result_in == '0) begin
                        e_d    = '0;
                        m_d    = '0;
                        zero_d = 1'b1;
                    end else if (bus.result_in[MW+1]) begin
                        if (exp_p1 >= all_ones) begin
                            // Saturate to infinity. The mantissa and sticky are meaningless here.
                            e_d   = '1;
                            m_d   = '0;
                            ovf_d = 1'b1;
                        end else begin
                            e_d      = exp_p1[EW-1:0];
                            m_d      = bus.result_in[MW+1:1];
                            sticky_d = bus.result_in[0];
                        end
                    end else if (bus.result_in[MW]) begin
                        e_d = bus.expoent_in;
                        m_d = bus.result_in[MW:0];
                    end else if (exp_in_w <= XW'(1)) begin
                        e_d   = '0;
                        m_d   = bus.result_in[MW:0];
                        unf_d = 1'b1;
                    end else begin
                        e_d     = bus.expoent_in;
                        m_d     = bus.result_in[MW:0];
                        state_d = StShift;
                    end
                end
            end

            StShift: begin
                m_d = m_shift;
                e_d = e_shifted[EW-1:0];
                if (m_shift[MW]) begin
                    state_d = StDone;
                end else if (e_shifted == XW'(1)) begin
                    // Leading zeros remain but the exponent is exhausted, so the result is denormal.
                    e_d     = '0;
                    unf_d   = 1'b1;
                    state_d = StDone;
                end
            end

            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            e_q      <= '0;
            m_q      <= '0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            m_q      <= m_d;
            sticky_q <= sticky_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.in_ready      = (state_q == StIdle);
    assign bus.out_valid     = (state_q == StDone);
    assign bus.busy_out      = (state_q != StIdle);
    assign bus.normal_e_out  = e_q;
    assign bus.normal_m_out  = m_q;
    assign bus.sticky_out    = sticky_q;
    assign bus.zero_out      = zero_q;
    assign bus.overflow_out  = ovf_q;
    assign bus.underflow_out = unf_q;
endmodule

// File: tb/tb_seq_normalizer.sv
// Directed bench for seq_normalizer with EXP_WIDTH=8, MANTISSA_WIDTH=23, SHIFT_STEP=4.
// Expected results are pushed to a scoreboard queue when a transaction is driven.
// They are popped and compared when out_valid appears.
module tb_seq_normalizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_normalizer_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

    seq_normalizer #(
        .EXP_WIDTH(8),
        .MANTISSA_WIDTH(23),
        .SHIFT_STEP(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [7:0]  e;
        logic [23:0] m;
        logic        st;
        logic        z;
        logic        o;
        logic        u;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] e, input logic [23:0] m, input logic st,
                                input logic z, input logic o, input logic u, input int lat);
        exp_t w;
        w.e = e; w.m = m; w.st = st; w.z = z; w.o = o; w.u = u; w.lat = lat;
        return w;
    endfunction

    task automatic cmp_fields(input string tag, input exp_t w);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".e"}, 32'(bus.normal_e_out), 32'(w.e));
        check({tag, ".m"}, 32'(bus.normal_m_out), 32'(w.m));
        check({tag, ".flags"},
              32'({bus.sticky_out, bus.zero_out, bus.overflow_out, bus.underflow_out}),
              32'({w.st, w.z, w.o, w.u}));
    endtask

    // Drive one transaction from idle and wait (bounded) for out_valid.
    // lat counts clock edges from the capture edge up to the first edge after which out_valid is seen.
    task automatic send(input logic [7:0] ex, input logic [24:0] r, input exp_t want,
                        output int lat);
        bus.in_valid   = 1'b1;
        bus.expoent_in = ex;
        bus.result_in  = r;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(want);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Pop the expected result, compare it, optionally hold off out_ready while
    // offering a new input, then complete the handshake.
    task automatic finish(input string tag, input int lat, input int hold);
        exp_t w;
        w = sb.pop_front();
        check({tag, ".latency"}, 32'(lat), 32'(w.lat));
        cmp_fields(tag, w);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid   = 1'b1;
            bus.expoent_in = 8'd50;
            bus.result_in  = 25'h0800000;
            @(posedge clk); #1;
            cmp_fields({tag, ".hold"}, w);
            check({tag, ".hold.in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".post.out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".post.in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        bit saw_valid;

        bus.in_valid   = 1'b0;
        bus.expoent_in = '0;
        bus.result_in  = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.busy", 32'(bus.busy_out), 32'd0);
        check("reset.e_m", 32'({bus.normal_e_out, bus.normal_m_out}), 32'd0);
        check("reset.flags",
              32'({bus.sticky_out, bus.zero_out, bus.overflow_out, bus.underflow_out}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero
        send(8'd90, 25'h0000000, mk(8'd0, 24'h0, 0, 1, 0, 0, 1), lat);
        finish("zero", lat, 0);
        // Carry with sticky
        send(8'd127, 25'h1800001, mk(8'd128, 24'hC00000, 1, 0, 0, 0, 1), lat);
        finish("carry", lat, 0);
        // Carry just below saturation
        send(8'd253, 25'h1000002, mk(8'd254, 24'h800001, 0, 0, 0, 0, 1), lat);
        finish("carry253", lat, 0);
        // Already normal
        send(8'd100, 25'h0C00000, mk(8'd100, 24'hC00000, 0, 0, 0, 0, 1), lat);
        finish("normal", lat, 0);
        // Low exponent
        send(8'd1, 25'h0400000, mk(8'd0, 24'h400000, 0, 0, 0, 1, 1), lat);
        finish("lowexp", lat, 0);
        // Maximum shift: 23 positions in six steps
        send(8'd127, 25'h0000001, mk(8'd104, 24'h800000, 0, 0, 0, 0, 7), lat);
        finish("maxshift", lat, 0);
        // Underflow during the shift
        send(8'd3, 25'h0000100, mk(8'd0, 24'h000400, 0, 0, 0, 1, 2), lat);
        finish("unf_mid", lat, 0);
        // Shift limited by the exponent on the third step
        send(8'd10, 25'h0000010, mk(8'd0, 24'h002000, 0, 0, 0, 1, 4), lat);
        finish("unf_limit", lat, 0);
        // Overflow
        send(8'd254, 25'h1000000, mk(8'hFF, 24'h0, 0, 0, 1, 0, 1), lat);
        finish("overflow", lat, 0);
        // Overflow from an all-ones exponent, with backpressure and an ignored offer
        send(8'd255, 25'h1000001, mk(8'hFF, 24'h0, 0, 0, 1, 0, 1), lat);
        finish("ovf_hold", lat, 3);
        // Flags cleared at the next capture
        send(8'd60, 25'h0000800, mk(8'd48, 24'h800000, 0, 0, 0, 0, 4), lat);
        finish("shift12", lat, 0);

        // Reset during SHIFT
        bus.in_valid   = 1'b1;
        bus.expoent_in = 8'd127;
        bus.result_in  = 25'h0000001;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy_before", 32'(bus.busy_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.busy", 32'(bus.busy_out), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.e_m", 32'({bus.normal_e_out, bus.normal_m_out}), 32'd0);
        check("rst.flags",
              32'({bus.sticky_out, bus.zero_out, bus.overflow_out, bus.underflow_out}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("rst.no_out_valid", 32'(saw_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Recovery after reset
        send(8'd127, 25'h1800001, mk(8'd128, 24'hC00000, 1, 0, 0, 0, 1), lat);
        finish("recover", lat, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
